// File: rtl/mantissa_divider.sv
// Radix-4 restoring divider for single-precision mantissas.
// Computes floor(dividend * 2^25 / divisor) as a 26-bit quotient plus a
// sticky bit over 13 iterations, retiring two restoring steps per cycle.
// A divisor without its hidden bit is flagged as div_zero and forces an
// all-ones quotient with sticky set, keeping the same latency.
module mantissa_divider (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] dividend,
    input  logic [23:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] quotient,
    output logic        sticky,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Final iteration index: 13 RUN edges produce 26 quotient bits.
    localparam logic [3:0] LAST_COUNT = 4'd12;

    state_t      state_r;
    logic [24:0] rem_r;
    logic [23:0] den_r;
    logic [25:0] quo_r;
    logic [3:0]  count_r;
    logic        div_zero_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [25:0] quotient_r;
    logic        sticky_r;

    logic [25:0] step1_s;
    logic [25:0] step2_s;
    logic [25:0] quo_next_s;
    logic [24:0] rem_next_s;

    // One restoring step: returns {q_bit, shifted partial remainder}.
    // The remainder is kept to 25 bits; a normalized divisor guarantees
    // nothing is lost by the shift.
    function automatic logic [25:0] restore_step(input logic [24:0] rem,
                                                 input logic [23:0] den);
        logic [24:0] diff;
        logic [25:0] res;
        diff = rem - {1'b0, den};
        if (rem >= {1'b0, den}) begin
            res = {1'b1, diff << 1};
        end else begin
            res = {1'b0, rem << 1};
        end
        return res;
    endfunction

    // Two chained restoring steps per cycle; the first yields the higher bit.
    always_comb begin
        step1_s    = restore_step(rem_r, den_r);
        step2_s    = restore_step(step1_s[24:0], den_r);
        quo_next_s = {quo_r[23:0], step1_s[25], step2_s[25]};
        rem_next_s = step2_s[24:0];
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= IDLE;
            rem_r       <= 25'd0;
            den_r       <= 24'd0;
            quo_r       <= 26'd0;
            count_r     <= 4'd0;
            div_zero_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= 26'd0;
            sticky_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        rem_r      <= {1'b0, dividend};
                        den_r      <= divisor;
                        quo_r      <= 26'd0;
                        count_r    <= 4'd0;
                        div_zero_r <= ~divisor[23];
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= quo_next_s;
                    count_r <= count_r + 4'd1;
                    if (count_r == LAST_COUNT) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        quotient_r  <= div_zero_r ? 26'h3FFFFFF : quo_next_s;
                        sticky_r    <= div_zero_r | (rem_next_s != 25'd0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign sticky    = sticky_r;
    assign div_zero  = div_zero_r;

endmodule

// File: doc/mantissa_divider.md
MANTISSA_DIVIDER -- requirements
Module: mantissa_divider

Interface
REQ-001 SHALL have no parameters; all widths fixed for single-precision mantissas.
REQ-002 CLK  input  1  rising-edge clock, sole clock of block.
REQ-003 nRST  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block idle, able to accept operands.
REQ-006 dividend  input  24  dividend mantissa, hidden bit at [23].
REQ-007 divisor  input  24  divisor mantissa, hidden bit at [23].
REQ-008 out_valid  output  1  result held and valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  26  floor(dividend*2^25/divisor), weight of bit 25 = 2^0 of the ratio.
REQ-011 sticky  output  1  final partial remainder nonzero.
REQ-012 div_zero  output  1  divisor[23]==0 at acceptance (zero/unnormalized divisor).

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Acceptance = in_valid & in_ready at a rising edge; on that edge: R <= {1'b0,dividend} (25 bits), D <= divisor, Q <= 0, count <= 0, div_zero <= ~divisor[23], state <= RUN.
REQ-015 In RUN, each edge SHALL retire two restoring steps (radix-4): per step, if R>=D then q_bit=1, R=R-D, else q_bit=0; then R=R<<1 (25-bit); Q shifts left, q_bit enters LSB; first step yields quotient[25].
REQ-016 The two steps per cycle SHALL be chained combinationally within one cycle; R never exceeds 25 bits for dividend<2*divisor.
REQ-017 count SHALL increment per RUN edge; on the 13th RUN edge (26 bits done) state <= DONE.
REQ-018 Latency SHALL be exactly 13 cycles: out_valid high in the cycle following the 13th RUN edge after acceptance.
REQ-019 sticky SHALL equal (R!=0) after the last step; quotient = Q.
REQ-020 If div_zero, quotient SHALL read 26'h3FFFFFF and sticky 1 in DONE; latency unchanged.
REQ-021 Unnormalized dividend (dividend[23]==0, incl. zero) SHALL be divided per REQ-015 without special handling (zero -> quotient 0, sticky 0).
REQ-022 quotient, sticky, div_zero SHALL be stable throughout DONE regardless of input activity.
REQ-023 In DONE with out_ready high at an edge: state <= IDLE; no acceptance on that same edge (in_ready low in DONE).
REQ-024 out_ready low SHALL hold DONE indefinitely; in_valid ignored outside IDLE.
REQ-025 Input operands SHALL be sampled only at acceptance; later changes have no effect.

Reset
REQ-026 nRST low SHALL immediately force state IDLE, R, D, Q, count to 0, sticky 0, div_zero 0, out_valid 0, in_ready 1 (after release), independent of CLK.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid follows.
REQ-028 First acceptance SHALL be possible on the first rising edge after nRST deasserts.

Verification
REQ-029 dividend=0x800000, divisor=0x800000 -> after 13 cycles quotient=0x2000000, sticky=0, div_zero=0.
REQ-030 dividend=0xFFFFFF, divisor=0x800000 -> quotient=0x3FFFFFC, sticky=0.
REQ-031 dividend=0x800000, divisor=0xC00000 -> quotient=0x1555555, sticky=1.
REQ-032 divisor=0x000000, any dividend -> div_zero=1, quotient=0x3FFFFFF, sticky=1 at cycle 13.
REQ-033 out_ready held low 20 cycles in DONE with in_valid high and new operands -> outputs unchanged, no acceptance; out_ready high one edge -> IDLE, next operands accepted next edge.
REQ-034 nRST pulsed low at RUN cycle 6 -> out_valid never asserts for that operation, in_ready=1 after release, next operation produces correct 13-cycle result; bench checks all results against reference model floor(a*2^25/b) over 10k random normalized pairs.
